// File: rtl/oam_dma_master.sv
// OAM DMA master: passes CPU bus traffic through to memory while idle, and on a
// write to ADDR_TRIGGER halts the CPU and copies one 256-byte page to ADDR_TARGET.
module oam_dma_master #(
    parameter logic [15:0] ADDR_TRIGGER = 16'h4014,
    parameter logic [15:0] ADDR_TARGET  = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr_out,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_ren,
    input  logic        cpu_wen,
    output logic [7:0]  cpu_data_in,
    output logic        cpu_halt,
    output logic [15:0] mem_addr_out,
    output logic [7:0]  mem_data_out,
    output logic        mem_ren,
    output logic        mem_wen,
    input  logic [7:0]  mem_data_in,
    output logic        dma_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t      state, state_next;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic [7:0]  data_buf;
    logic        parity;
    logic        trigger;

    assign trigger = (state == S_IDLE) && cpu_wen && (cpu_addr_out == ADDR_TRIGGER);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            page     <= '0;
            idx      <= '0;
            data_buf <= '0;
            parity   <= 1'b0;
        end else begin
            // parity free-runs in every state; it decides whether HALT needs an ALIGN slot
            parity <= ~parity;
            state  <= state_next;
            if (trigger) begin
                page <= cpu_data_out;
                idx  <= '0;
            end
            if (state == S_READ)
                data_buf <= mem_data_in;
            if (state == S_WRITE)
                idx <= idx + 8'd1;
        end
    end

    always_comb begin
        state_next   = state;
        cpu_data_in  = 8'h00;
        mem_addr_out = '0;
        mem_data_out = '0;
        mem_ren      = 1'b0;
        mem_wen      = 1'b0;

        case (state)
            S_IDLE: begin
                mem_addr_out = cpu_addr_out;
                mem_data_out = cpu_data_out;
                mem_ren      = cpu_ren;
                mem_wen      = cpu_wen;
                cpu_data_in  = mem_data_in;
                if (trigger)
                    state_next = S_HALT;
            end
            S_HALT: begin
                state_next = parity ? S_ALIGN : S_READ;
            end
            S_ALIGN: begin
                state_next = S_READ;
            end
            S_READ: begin
                mem_addr_out = {page, idx};
                mem_ren      = 1'b1;
                state_next   = S_WRITE;
            end
            S_WRITE: begin
                mem_addr_out = ADDR_TARGET;
                mem_data_out = data_buf;
                mem_wen      = 1'b1;
                state_next   = (idx == 8'hFF) ? S_IDLE : S_READ;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign dma_busy = (state != S_IDLE);
    assign cpu_halt = dma_busy;

endmodule

// File: tb/tb_oam_dma_master.sv
// Directed/randomized bench for oam_dma_master with a byte-array memory model
// and a cycle-level expectation of the transfer built from the transfer rules.
module tb_oam_dma_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr_out;
    logic [7:0]  cpu_data_out;
    logic        cpu_ren;
    logic        cpu_wen;
    logic [7:0]  cpu_data_in;
    logic        cpu_halt;
    logic [15:0] mem_addr_out;
    logic [7:0]  mem_data_out;
    logic        mem_ren;
    logic        mem_wen;
    logic [7:0]  mem_data_in;
    logic        dma_busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:65535];
    logic       par_model;

    oam_dma_master #(
        .ADDR_TRIGGER(16'h4014),
        .ADDR_TARGET (16'h2004)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_addr_out(cpu_addr_out),
        .cpu_data_out(cpu_data_out),
        .cpu_ren     (cpu_ren),
        .cpu_wen     (cpu_wen),
        .cpu_data_in (cpu_data_in),
        .cpu_halt    (cpu_halt),
        .mem_addr_out(mem_addr_out),
        .mem_data_out(mem_data_out),
        .mem_ren     (mem_ren),
        .mem_wen     (mem_wen),
        .mem_data_in (mem_data_in),
        .dma_busy    (dma_busy)
    );

    always #5 clk = ~clk;

    // Combinational-read, edge-commit memory
    assign mem_data_in = mem[mem_addr_out];
    always @(posedge clk) if (mem_wen) mem[mem_addr_out] <= mem_data_out;

    // Free-running parity: 0 after a reset edge, flips on every other edge
    always @(posedge clk) par_model <= rst ? 1'b0 : ~par_model;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Triggers a transfer of page pg. want_par: 0/1 forces HALT parity, 2 = any.
    // abort_wr >= 0 asserts reset during that (0-based) WRITE cycle, with a trigger also driven.
    task automatic do_transfer(input logic [7:0] pg, input int want_par, input int abort_wr);
        logic [7:0] snap [256];
        int exp_par, n, rd, wr, slot;
        bit aborted;
        for (int i = 0; i < 256; i++) snap[i] = mem[{pg, 8'(i)}];
        if (want_par != 2 && int'(par_model) == want_par) tick();
        exp_par = par_model ? 0 : 1;

        cpu_addr_out = 16'h4014; cpu_data_out = pg; cpu_wen = 1'b1; cpu_ren = 1'b0;
        #1;
        check("trig_pass_wen", mem_wen, 1);
        check("trig_pass_addr", mem_addr_out, 16'h4014);
        check("trig_pass_data", mem_data_out, pg);
        check("trig_idle_busy", dma_busy, 0);
        tick();
        cpu_wen = 1'b0; cpu_addr_out = 16'h0000; cpu_data_out = 8'h00;

        n = 0; rd = 0; wr = 0; aborted = 0;
        while (dma_busy && n < 600 && !aborted) begin
            check("halt_eq_busy", cpu_halt, 1);
            check("busy_cpu_rdata", cpu_data_in, 8'h00);
            if (n < 1 + exp_par) begin
                check("lead_idle_bus", {mem_ren, mem_wen}, 2'b00);
            end else begin
                slot = n - 1 - exp_par;
                if (slot % 2 == 0) begin
                    check("rd_strobes", {mem_ren, mem_wen}, 2'b10);
                    check("rd_addr", mem_addr_out, {pg, 8'(rd)});
                    rd++;
                end else begin
                    check("wr_strobes", {mem_ren, mem_wen}, 2'b01);
                    check("wr_addr", mem_addr_out, 16'h2004);
                    check("wr_data", mem_data_out, (wr < 256) ? snap[wr] : 8'hxx);
                    if (wr == abort_wr) begin
                        rst = 1'b1;
                        cpu_addr_out = 16'h4014; cpu_data_out = 8'h55; cpu_wen = 1'b1;
                        aborted = 1;
                    end
                    wr++;
                end
            end
            n++;
            tick();
        end

        if (aborted) begin
            rst = 1'b0; cpu_wen = 1'b0; cpu_addr_out = 16'h0000;
            check("abort_busy", dma_busy, 0);
            check("abort_halt", cpu_halt, 0);
        end else begin
            check("busy_len", n, 513 + exp_par);
            check("read_count", rd, 256);
            check("write_count", wr, 256);
            check("end_halt", cpu_halt, 0);
        end
    endtask

    initial begin
        int bad;
        logic [7:0] pg, v;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst = 1'b1; cpu_addr_out = '0; cpu_data_out = '0; cpu_ren = 1'b0; cpu_wen = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state and idle passthrough
        check("rst_busy", dma_busy, 0);
        check("rst_halt", cpu_halt, 0);
        cpu_addr_out = 16'h1234; cpu_ren = 1'b1;
        #1;
        check("pass_rd_addr", mem_addr_out, 16'h1234);
        check("pass_rd_ren", mem_ren, 1);
        check("pass_rd_data", cpu_data_in, mem[16'h1234]);
        tick();

        // Non-trigger write and read near the trigger address
        cpu_ren = 1'b0; cpu_wen = 1'b1; cpu_addr_out = 16'h4015; cpu_data_out = 8'h1F;
        #1;
        check("nt_wr_addr", mem_addr_out, 16'h4015);
        check("nt_wr_data", mem_data_out, 8'h1F);
        check("nt_wr_wen", mem_wen, 1);
        tick();
        check("nt_wr_busy", dma_busy, 0);
        check("nt_wr_commit", mem[16'h4015], 8'h1F);
        cpu_wen = 1'b0; cpu_ren = 1'b1; cpu_addr_out = 16'h4016;
        v = 8'($urandom); mem[16'h4016] = v;
        #1;
        check("nt_rd_data", cpu_data_in, v);
        check("nt_rd_strobes", {mem_ren, mem_wen}, 2'b10);
        tick();
        check("nt_rd_busy", dma_busy, 0);
        cpu_ren = 1'b0;

        // Even-parity and odd-parity runs
        do_transfer(8'h02, 0, -1);
        tick();
        pg = 8'($urandom_range(8'h50, 8'hFF));
        do_transfer(pg, 1, -1);
        tick();

        // Data integrity followed by a back-to-back trigger in the first idle cycle
        for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'h5A;
        do_transfer(8'h03, 2, -1);
        do_transfer(8'h07, 2, -1);
        tick();

        // Reset at the 100th WRITE cycle, trigger held during reset
        pg = 8'($urandom_range(8'h50, 8'hFF));
        do_transfer(pg, 2, 99);
        cpu_addr_out = 16'h0456; cpu_ren = 1'b1;
        #1;
        check("post_abort_pass_addr", mem_addr_out, 16'h0456);
        check("post_abort_pass_data", cpu_data_in, mem[16'h0456]);
        cpu_ren = 1'b0; cpu_addr_out = 16'h0000;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (dma_busy || mem_wen || mem_ren) bad++;
        end
        check("post_abort_quiet", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
